// File: rtl/mdu_ctrl.sv
// Sequencing controller for the EX-stage multiply/divide unit.
// Launches MULT/MULTU/DIV/DIVU, holds busy for a fixed latency, then commits
// the latched result to HI/LO. MTHI/MTLO write HI/LO directly when idle.
// A flush cancels an in-flight op without committing it.
module mdu_ctrl #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [2:0]  md_op,
  input  logic [31:0] srcA,
  input  logic [31:0] srcB,
  input  logic        flush,
  output logic        start,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] pend_hi;
  logic [31:0] pend_lo;
  logic        pend_commit;
  logic        issue_ok;
  logic [63:0] res;
  logic        div_zero;

  // Full 64-bit product; operands are sign- or zero-extended before multiplying
  function automatic logic [63:0] mul_full(input logic [31:0] a, input logic [31:0] b,
                                           input logic sgn);
    logic [63:0] ea;
    logic [63:0] eb;
    ea = sgn ? {{32{a[31]}}, a} : {32'b0, a};
    eb = sgn ? {{32{b[31]}}, b} : {32'b0, b};
    return ea * eb;
  endfunction

  // Returns {remainder, quotient}. Signed division works on magnitudes and then
  // restores signs: quotient truncates toward zero, remainder follows the dividend.
  // The magnitude form also makes 0x80000000 / -1 fall out as 0x80000000 rem 0.
  function automatic logic [63:0] div_full(input logic [31:0] a, input logic [31:0] b,
                                           input logic sgn);
    logic        neg_a;
    logic        neg_b;
    logic [31:0] ua;
    logic [31:0] ub;
    logic [31:0] q;
    logic [31:0] r;
    neg_a = sgn & a[31];
    neg_b = sgn & b[31];
    ua = neg_a ? -a : a;
    ub = neg_b ? -b : b;
    if (ub == 32'd0) begin
      q = 32'd0;
      r = 32'd0;
    end else begin
      q = ua / ub;
      r = ua % ub;
    end
    if (neg_a ^ neg_b) q = -q;
    if (neg_a) r = -r;
    return {r, q};
  endfunction

  // An MD op is accepted only when the unit is idle and no flush is pending
  assign issue_ok = op_valid & ~busy & ~flush;
  assign start    = issue_ok & ~md_op[2];
  assign div_zero = md_op[1] & (srcB == 32'd0);

  // Result of the op being launched this cycle (md_op[0]=0 selects signed)
  always_comb begin
    res = 64'd0;
    if (md_op[1]) res = div_full(srcA, srcB, ~md_op[0]);
    else          res = mul_full(srcA, srcB, ~md_op[0]);
  end

  // Controller FSM: launch, count down, commit or cancel; MTHI/MTLO while idle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      busy        <= 1'b0;
      hi          <= 32'd0;
      lo          <= 32'd0;
      pend_hi     <= 32'd0;
      pend_lo     <= 32'd0;
      pend_commit <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            pend_hi     <= res[63:32];
            pend_lo     <= res[31:0];
            pend_commit <= ~div_zero;
            cnt         <= md_op[1] ? 4'(DIV_CYCLES) : 4'(MUL_CYCLES);
            busy        <= 1'b1;
            state       <= RUN;
          end else if (issue_ok && md_op == 3'd4) begin
            hi <= srcA;
          end else if (issue_ok && md_op == 3'd5) begin
            lo <= srcA;
          end
        end
        RUN: begin
          if (flush) begin
            cnt   <= 4'd0;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (cnt == 4'd1) begin
            if (pend_commit) begin
              hi <= pend_hi;
              lo <= pend_lo;
            end
            cnt   <= 4'd0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
